// File: rtl/spi_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_arbiter_if
// Description : Two-port register-access handshake plus flat config export.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_reg_arbiter_if #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3
);
    logic                      ena;

    logic                      req0;
    logic                      we0;
    logic [ADDR_W-1:0]         addr0;
    logic [WIDTH-1:0]          wdata0;
    logic                      ack0;
    logic [WIDTH-1:0]          rdata0;
    logic                      err0;

    logic                      req1;
    logic                      we1;
    logic [ADDR_W-1:0]         addr1;
    logic [WIDTH-1:0]          wdata1;
    logic                      ack1;
    logic [WIDTH-1:0]          rdata1;
    logic                      err1;

    logic                      busy;
    logic [NUM_REGS*WIDTH-1:0] config_regs;

    modport master (
        output ena,
        output req0, we0, addr0, wdata0,
        input  ack0, rdata0, err0,
        output req1, we1, addr1, wdata1,
        input  ack1, rdata1, err1,
        input  busy, config_regs
    );

    modport slave (
        input  ena,
        input  req0, we0, addr0, wdata0,
        output ack0, rdata0, err0,
        input  req1, we1, addr1, wdata1,
        output ack1, rdata1, err1,
        output busy, config_regs
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_arbiter
// Description : Config register bank shared by two requesters, round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3
) (
    input  wire logic        clk,
    input  wire logic        rstb,
    spi_reg_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_gnt;
    logic               r_last_gnt;
    logic               r_we;
    logic               r_range_err;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   r_rdata0;
    logic [WIDTH-1:0]   r_rdata1;
    logic [1:0]         r_ack;
    logic [1:0]         r_err;
    logic [WIDTH-1:0]   r_bank [NUM_REGS];

    logic               w_any_req;
    logic               w_pick;
    logic               w_in_range;
    logic [WIDTH-1:0]   w_rd_val;

    assign w_any_req  = bus.req0 | bus.req1;
    // Under contention the port that was not served last goes next.
    assign w_pick     = (bus.req0 & bus.req1) ? ~r_last_gnt : bus.req1;
    assign w_in_range = ({{(32-ADDR_W){1'b0}}, r_addr} < 32'(NUM_REGS));
    assign w_rd_val   = w_in_range ? r_bank[r_addr] : '0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_we        <= 1'b0;
            r_range_err <= 1'b0;
            r_busy      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_ack       <= 2'b00;
            r_err       <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            r_ack <= 2'b00;
            r_err <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (bus.ena && w_any_req) begin
                        r_gnt   <= w_pick;
                        r_we    <= w_pick ? bus.we1    : bus.we0;
                        r_addr  <= w_pick ? bus.addr1  : bus.addr0;
                        r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_range_err <= ~w_in_range;
                    if (w_in_range && r_we) begin
                        r_bank[r_addr] <= r_wdata;
                    end else if (r_gnt) begin
                        r_rdata1 <= w_rd_val;
                    end else begin
                        r_rdata0 <= w_rd_val;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack[r_gnt] <= 1'b1;
                    r_err[r_gnt] <= r_range_err;
                    r_last_gnt   <= r_gnt;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0   = r_ack[0];
    assign bus.ack1   = r_ack[1];
    assign bus.err0   = r_err[0];
    assign bus.err1   = r_err[1];
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;
    assign bus.busy   = r_busy;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
        assign bus.config_regs[gi*WIDTH +: WIDTH] = r_bank[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_arbiter
// Description : Directed bench with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_arbiter;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    spi_reg_arbiter_if #(.NUM_REGS(8), .WIDTH(8), .ADDR_W(3)) bus8 ();
    spi_reg_arbiter_if #(.NUM_REGS(6), .WIDTH(8), .ADDR_W(3)) bus6 ();

    spi_reg_arbiter #(.NUM_REGS(8), .WIDTH(8), .ADDR_W(3)) dut8 (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus8)
    );

    spi_reg_arbiter #(.NUM_REGS(6), .WIDTH(8), .ADDR_W(3)) dut6 (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus6)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model of the 8-register instance: an access granted at
    // edge G lands in the bank at G+1, acks after G+2, next grant from G+3.
    logic [7:0]  m_bank [8];
    bit          m_pend, m_last, m_gp, m_wr, m_rd_acc, m_res_err, m_inr, m_we;
    int unsigned m_cyc, m_gcyc;
    logic [2:0]  m_addr;
    logic [7:0]  m_wval, m_res_rd;
    bit          m_ack [2];
    bit          m_err [2];
    bit          m_isrd [2];
    logic [7:0]  m_rdata [2];

    initial begin
        m_cyc = 0;
        forever begin
            @(posedge clk or negedge rstb);
            if (!rstb) begin
                for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
                m_pend = 1'b0;
                m_last = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    m_ack[p] = 1'b0; m_err[p] = 1'b0; m_isrd[p] = 1'b0; m_rdata[p] = 8'h00;
                end
            end else begin
                m_cyc++;
                m_ack[0] = 1'b0; m_ack[1] = 1'b0;
                m_err[0] = 1'b0; m_err[1] = 1'b0;
                if (m_pend && m_cyc == m_gcyc + 1 && m_wr) m_bank[m_addr] = m_wval;
                if (m_pend && m_cyc == m_gcyc + 2) begin
                    m_ack[m_gp]  = 1'b1;
                    m_err[m_gp]  = m_res_err;
                    m_isrd[m_gp] = m_rd_acc;
                    if (m_rd_acc) m_rdata[m_gp] = m_res_rd;
                    m_last = m_gp;
                    m_pend = 1'b0;
                end else if (!m_pend && bus8.ena && (bus8.req0 || bus8.req1)) begin
                    m_gp      = (bus8.req0 && bus8.req1) ? !m_last : bus8.req1;
                    m_addr    = m_gp ? bus8.addr1  : bus8.addr0;
                    m_wval    = m_gp ? bus8.wdata1 : bus8.wdata0;
                    m_we      = m_gp ? bus8.we1    : bus8.we0;
                    m_inr     = (int'(m_addr) < 8);
                    m_wr      = m_we && m_inr;
                    m_rd_acc  = !m_we || !m_inr;
                    m_res_err = !m_inr;
                    m_res_rd  = m_inr ? m_bank[m_addr] : 8'h00;
                    m_pend    = 1'b1;
                    m_gcyc    = m_cyc;
                end
            end
        end
    end

    function automatic logic [63:0] m_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_bank[i];
        return f;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", 64'(bus8.busy), 64'(m_pend));
                check("ack0", 64'(bus8.ack0), 64'(m_ack[0]));
                check("ack1", 64'(bus8.ack1), 64'(m_ack[1]));
                check("err0", 64'(bus8.err0), 64'(m_err[0]));
                check("err1", 64'(bus8.err1), 64'(m_err[1]));
                if (m_ack[0] && m_isrd[0]) check("rdata0", 64'(bus8.rdata0), 64'(m_rdata[0]));
                if (m_ack[1] && m_isrd[1]) check("rdata1", 64'(bus8.rdata1), 64'(m_rdata[1]));
                check("config_regs", bus8.config_regs, m_flat());
            end
        end
    end

    task automatic drive(input bit d6, input bit p, input bit r, input bit we,
                         input logic [2:0] a, input logic [7:0] wd);
        if (d6) begin
            bus6.req0 = r; bus6.we0 = we; bus6.addr0 = a; bus6.wdata0 = wd;
        end else if (p) begin
            bus8.req1 = r; bus8.we1 = we; bus8.addr1 = a; bus8.wdata1 = wd;
        end else begin
            bus8.req0 = r; bus8.we0 = we; bus8.addr0 = a; bus8.wdata0 = wd;
        end
    endtask

    function automatic logic ackv(input bit d6, input bit p);
        return d6 ? bus6.ack0 : (p ? bus8.ack1 : bus8.ack0);
    endfunction

    task automatic access(input bit d6, input bit p, input bit we, input logic [2:0] a,
                          input logic [7:0] wd, output logic [7:0] rd, output logic er,
                          output logic oth, output int lat);
        @(negedge clk);
        drive(d6, p, 1'b1, we, a, wd);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ackv(d6, p) && lat < 20);
        check("ack_seen", 64'(ackv(d6, p)), 64'd1);
        rd  = d6 ? bus6.rdata0 : (p ? bus8.rdata1 : bus8.rdata0);
        er  = d6 ? bus6.err0   : (p ? bus8.err1   : bus8.err0);
        oth = d6 ? bus6.ack1   : (p ? bus8.ack0   : bus8.ack1);
        drive(d6, p, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    logic [7:0] rd;
    logic       er, oth;
    int         lat;
    int         g [4];
    int         ng;

    initial begin
        bus8.ena = 1'b1; bus6.ena = 1'b1;
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        drive(0, 1, 0, 0, 3'd0, 8'h00);
        drive(1, 0, 0, 0, 3'd0, 8'h00);
        bus6.req1 = 1'b0; bus6.we1 = 1'b0; bus6.addr1 = 3'd0; bus6.wdata1 = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus8.busy), 64'd0);
        check("rst_cfg", bus8.config_regs, 64'd0);
        check("rst_ack", 64'({bus8.ack1, bus8.ack0, bus8.err1, bus8.err0}), 64'd0);
        check("rst_rdata", 64'({bus8.rdata1, bus8.rdata0}), 64'd0);
        rstb   = 1'b1;
        chk_en = 1'b1;

        // Scenario 1: write 0xA5 to addr 2 from port 0
        access(0, 0, 1, 3'd2, 8'hA5, rd, er, oth, lat);
        check("s1_latency", 64'(lat), 64'd3);
        check("s1_err0", 64'(er), 64'd0);
        check("s1_cfg", bus8.config_regs, 64'h0000_0000_00A5_0000);

        // Scenario 2: port 1 reads addr 2
        access(0, 1, 0, 3'd2, 8'h00, rd, er, oth, lat);
        check("s2_rdata1", 64'(rd), 64'hA5);
        check("s2_err1", 64'(er), 64'd0);
        check("s2_ack0", 64'(oth), 64'd0);

        // Scenario 3: continuous contention on addr 5
        for (int i = 0; i < 4; i++) g[i] = 9;
        ng = 0;
        @(negedge clk);
        drive(0, 0, 1, 1, 3'd5, 8'h11);
        drive(0, 1, 1, 1, 3'd5, 8'h22);
        for (int t = 0; t < 30 && ng < 4; t++) begin
            @(negedge clk);
            if (bus8.ack0) begin g[ng] = 0; ng++; end
            if (bus8.ack1 && ng < 4) begin g[ng] = 1; ng++; end
        end
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        drive(0, 1, 0, 0, 3'd0, 8'h00);
        check("s3_grant_count", 64'(ng), 64'd4);
        check("s3_order", 64'({g[0][3:0], g[1][3:0], g[2][3:0], g[3][3:0]}), 64'h0101);
        check("s3_addr5", 64'(bus8.config_regs[47:40]), 64'h22);

        // Scenario 4: top address in range on 8 regs, out of range on 6 regs
        access(0, 0, 1, 3'd7, 8'hFF, rd, er, oth, lat);
        check("s4_err0_8", 64'(er), 64'd0);
        check("s4_cfg8", bus8.config_regs, 64'hFF00_2200_00A5_0000);
        access(0, 1, 0, 3'd7, 8'h00, rd, er, oth, lat);
        check("s4_rd7", 64'(rd), 64'hFF);
        access(1, 0, 1, 3'd5, 8'h5A, rd, er, oth, lat);
        check("s4_err0_6_in", 64'(er), 64'd0);
        check("s4_cfg6_a", 64'(bus6.config_regs), 64'h5A00_0000_0000);
        access(1, 0, 1, 3'd7, 8'hFF, rd, er, oth, lat);
        check("s4_err0_6_out", 64'(er), 64'd1);
        check("s4_ack1_6", 64'(oth), 64'd0);
        @(negedge clk);
        check("s4_cfg6_b", 64'(bus6.config_regs), 64'h5A00_0000_0000);
        access(1, 0, 0, 3'd6, 8'h00, rd, er, oth, lat);
        check("s4_rd6_err", 64'(er), 64'd1);
        check("s4_rd6_data", 64'(rd), 64'd0);

        // Scenario 5: enable low holds off the grant
        @(negedge clk);
        bus8.ena = 1'b0;
        drive(0, 0, 1, 1, 3'd4, 8'h77);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("s5_noack", 64'(bus8.ack0), 64'd0);
        end
        bus8.ena = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus8.ack0 && lat < 20);
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        check("s5_latency", 64'(lat), 64'd3);
        check("s5_cfg", bus8.config_regs, 64'hFF00_2277_00A5_0000);

        // Scenario 6: reset while a write is in ACCESS
        @(negedge clk);
        drive(0, 0, 1, 1, 3'd3, 8'h3C);
        @(negedge clk);
        check("s6_busy_mid", 64'(bus8.busy), 64'd1);
        #2 rstb = 1'b0;
        drive(0, 0, 0, 0, 3'd0, 8'h00);
        repeat (2) begin
            @(negedge clk);
            check("s6_rst_ack", 64'(bus8.ack0), 64'd0);
            check("s6_rst_busy", 64'(bus8.busy), 64'd0);
            check("s6_rst_cfg", bus8.config_regs, 64'd0);
        end
        rstb = 1'b1;
        access(0, 0, 1, 3'd3, 8'h3C, rd, er, oth, lat);
        check("s6_latency", 64'(lat), 64'd3);
        check("s6_cfg", bus8.config_regs, 64'h0000_0000_3C00_0000);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
